// File: rtl/tpu_apb_pkg.sv
// Shared definitions for the TPU APB host sequencer.
// Holds default bus widths, TPU register map, status/control bit positions,
// sequencer state encoding and step indices.
package tpu_apb_pkg;

   localparam int unsigned DEF_ADDRWIDTH = 16;
   localparam int unsigned DEF_DATAWIDTH = 32;

   // TPU register map
   localparam logic [31:0] REG_ENABLES_ADDR  = 32'h0000_0000;
   localparam logic [31:0] REG_MEAN_ADDR     = 32'h0000_0004;
   localparam logic [31:0] REG_INV_VAR_ADDR  = 32'h0000_0008;
   localparam logic [31:0] REG_STDN_TPU_ADDR = 32'h0000_000C;

   // Control/status bit positions in REG_STDN_TPU
   localparam int unsigned START_BIT = 0;
   localparam int unsigned DONE_BIT  = 31;

   typedef logic [2:0] step_t;

   localparam step_t STEP_ENABLES = 3'd0;
   localparam step_t STEP_MEAN    = 3'd1;
   localparam step_t STEP_INV_VAR = 3'd2;
   localparam step_t STEP_START   = 3'd3;
   localparam step_t STEP_POLL    = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SETUP     = 3'd1,
      ST_ACCESS    = 3'd2,
      ST_GAP       = 3'd3,
      ST_POLL_WAIT = 3'd4,
      ST_FINISH    = 3'd5
   } seq_state_e;

endpackage

// File: rtl/apb_xfer.sv
// Single APB transfer engine (SETUP then ACCESS until PREADY).
// Ports: req_c/req_* start a transfer while the bus is idle; ack_c flags the
//        completing cycle; rdata holds the last read data; APB master outputs
//        are all registered and return to zero after completion.
module apb_xfer #(
   parameter int unsigned AW = 16,
   parameter int unsigned DW = 32
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          req_c,
   input  logic [AW-1:0] req_addr,
   input  logic          req_write,
   input  logic [DW-1:0] req_wdata,
   output logic          ack_c,
   output logic [DW-1:0] rdata,
   output logic [AW-1:0] paddr,
   output logic          pwrite,
   output logic          psel,
   output logic          penable,
   output logic [DW-1:0] pwdata,
   input  logic [DW-1:0] prdata,
   input  logic          pready
);

   logic          psel_q, psel_d;
   logic          penable_q, penable_d;
   logic          pwrite_q, pwrite_d;
   logic [AW-1:0] paddr_q, paddr_d;
   logic [DW-1:0] pwdata_q, pwdata_d;
   logic [DW-1:0] rdata_q, rdata_d;

   // Transfer phase sequencing; PREADY only matters during ACCESS
   always_comb begin
      psel_d    = psel_q;
      penable_d = penable_q;
      pwrite_d  = pwrite_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      rdata_d   = rdata_q;
      ack_c     = psel_q & penable_q & pready;
      if (req_c && !psel_q) begin
         psel_d    = 1'b1;
         penable_d = 1'b0;
         pwrite_d  = req_write;
         paddr_d   = req_addr;
         pwdata_d  = req_write ? req_wdata : '0;
      end else if (psel_q && !penable_q) begin
         penable_d = 1'b1;
      end else if (ack_c) begin
         if (!pwrite_q) rdata_d = prdata;
         psel_d    = 1'b0;
         penable_d = 1'b0;
         pwrite_d  = 1'b0;
         paddr_d   = '0;
         pwdata_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         rdata_q   <= '0;
      end else begin
         psel_q    <= psel_d;
         penable_q <= penable_d;
         pwrite_q  <= pwrite_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
         rdata_q   <= rdata_d;
      end
   end

   assign psel    = psel_q;
   assign penable = penable_q;
   assign pwrite  = pwrite_q;
   assign paddr   = paddr_q;
   assign pwdata  = pwdata_q;
   assign rdata   = rdata_q;

endmodule

// File: rtl/apb_host_seq.sv
// APB host sequencer for one TPU run: programs enables, mean, inverse
// variance, sets the start bit, then polls the status register until the
// done bit is seen or MAX_POLLS reads have been issued.
// Ports: cmd_valid/cmd_ready accept a run with cfg_* captured; APB master
//        P* signals; busy/done/timeout report run status; poll_count counts
//        status reads of the current or last run.
module apb_host_seq
   import tpu_apb_pkg::*;
#(
   parameter int unsigned REG_ADDRWIDTH = DEF_ADDRWIDTH,
   parameter int unsigned REG_DATAWIDTH = DEF_DATAWIDTH,
   parameter int unsigned POLL_GAP      = 4,
   parameter int unsigned MAX_POLLS     = 1024
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [3:0]               cfg_enables,
   input  logic [7:0]               cfg_mean,
   input  logic [7:0]               cfg_inv_var,
   output logic [REG_ADDRWIDTH-1:0] PADDR,
   output logic                     PWRITE,
   output logic                     PSEL,
   output logic                     PENABLE,
   output logic [REG_DATAWIDTH-1:0] PWDATA,
   input  logic [REG_DATAWIDTH-1:0] PRDATA,
   input  logic                     PREADY,
   output logic                     busy,
   output logic                     done,
   output logic                     timeout,
   output logic [15:0]              poll_count
);

   localparam int unsigned AW = REG_ADDRWIDTH;
   localparam int unsigned DW = REG_DATAWIDTH;

   seq_state_e    state_q, state_d;
   step_t         step_q, step_d;
   logic [3:0]    en_q, en_d;
   logic [7:0]    mean_q, mean_d;
   logic [7:0]    inv_q, inv_d;
   logic [15:0]   poll_q, poll_d;
   logic [15:0]   wait_q, wait_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          timeout_q, timeout_d;
   logic          cmd_ready_q, cmd_ready_d;

   logic          req_c;
   logic [AW-1:0] req_addr_c;
   logic          req_write_c;
   logic [DW-1:0] req_wdata_c;
   logic          ack_c;
   logic [DW-1:0] rdata;
   logic          unused_rdata;

   assign unused_rdata = ^rdata;

   // Sequencer next-state, run bookkeeping and status pulses
   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      en_d      = en_q;
      mean_d    = mean_q;
      inv_d     = inv_q;
      poll_d    = poll_q;
      wait_d    = wait_q;
      done_d    = 1'b0;
      timeout_d = 1'b0;
      req_c     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               en_d    = cfg_enables;
               mean_d  = cfg_mean;
               inv_d   = cfg_inv_var;
               step_d  = STEP_ENABLES;
               poll_d  = 16'd0;
               state_d = ST_SETUP;
               req_c   = 1'b1;
            end
         end
         ST_SETUP: state_d = ST_ACCESS;
         ST_ACCESS: begin
            if (ack_c) begin
               state_d = ST_GAP;
               if (step_q == STEP_POLL && poll_q != 16'hFFFF)
                  poll_d = poll_q + 16'd1;
            end
         end
         ST_GAP: begin
            if (step_q != STEP_POLL) begin
               step_d  = step_q + 3'd1;
               state_d = ST_SETUP;
               req_c   = 1'b1;
            end else if (rdata[DONE_BIT]) begin
               state_d = ST_FINISH;
               done_d  = 1'b1;
            end else if (32'(poll_q) >= MAX_POLLS) begin
               state_d   = ST_FINISH;
               timeout_d = 1'b1;
            end else if (POLL_GAP == 0) begin
               state_d = ST_SETUP;
               req_c   = 1'b1;
            end else begin
               state_d = ST_POLL_WAIT;
               wait_d  = 16'd0;
            end
         end
         ST_POLL_WAIT: begin
            if (wait_q == 16'(POLL_GAP - 1)) begin
               state_d = ST_SETUP;
               req_c   = 1'b1;
            end else begin
               wait_d = wait_q + 16'd1;
            end
         end
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
      busy_d      = (state_d != ST_IDLE) && (state_d != ST_FINISH);
      cmd_ready_d = (state_d == ST_IDLE);
   end

   // Step index selects address, direction and write data
   always_comb begin
      req_addr_c  = '0;
      req_write_c = 1'b0;
      req_wdata_c = '0;
      unique case (step_d)
         STEP_ENABLES: begin
            req_addr_c  = AW'(REG_ENABLES_ADDR);
            req_write_c = 1'b1;
            req_wdata_c = DW'(en_d);
         end
         STEP_MEAN: begin
            req_addr_c  = AW'(REG_MEAN_ADDR);
            req_write_c = 1'b1;
            req_wdata_c = DW'(mean_d);
         end
         STEP_INV_VAR: begin
            req_addr_c  = AW'(REG_INV_VAR_ADDR);
            req_write_c = 1'b1;
            req_wdata_c = DW'(inv_d);
         end
         STEP_START: begin
            req_addr_c  = AW'(REG_STDN_TPU_ADDR);
            req_write_c = 1'b1;
            req_wdata_c = DW'(1) << START_BIT;
         end
         default: begin
            req_addr_c  = AW'(REG_STDN_TPU_ADDR);
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         step_q      <= STEP_ENABLES;
         en_q        <= 4'd0;
         mean_q      <= 8'd0;
         inv_q       <= 8'd0;
         poll_q      <= 16'd0;
         wait_q      <= 16'd0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         timeout_q   <= 1'b0;
         cmd_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         step_q      <= step_d;
         en_q        <= en_d;
         mean_q      <= mean_d;
         inv_q       <= inv_d;
         poll_q      <= poll_d;
         wait_q      <= wait_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         timeout_q   <= timeout_d;
         cmd_ready_q <= cmd_ready_d;
      end
   end

   apb_xfer #(
      .AW (AW),
      .DW (DW)
   ) u_xfer (
      .clk       (clk),
      .resetn    (resetn),
      .req_c     (req_c),
      .req_addr  (req_addr_c),
      .req_write (req_write_c),
      .req_wdata (req_wdata_c),
      .ack_c     (ack_c),
      .rdata     (rdata),
      .paddr     (PADDR),
      .pwrite    (PWRITE),
      .psel      (PSEL),
      .penable   (PENABLE),
      .pwdata    (PWDATA),
      .prdata    (PRDATA),
      .pready    (PREADY)
   );

   assign cmd_ready  = cmd_ready_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign timeout    = timeout_q;
   assign poll_count = poll_q;

endmodule
